// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding control for the 5-stage MIPS32 pipeline.
// Shadows EX/MEM/WB to drive stalls, flushes and EX operand selects.
module hazard_forward_unit #(
   parameter int RA_W     = 5,
   parameter int LOAD_LAT = 1,
   parameter int BR_STAGE = 3,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs,
   input  logic [RA_W-1:0]  id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic [RA_W-1:0]  id_wreg,
   input  logic             id_jump,
   input  logic             br_taken,
   output logic             stall,
   output logic             bubble_idex,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             flush_exmem,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef struct packed {
      logic            valid;
      logic            regwrite;
      logic            memread;
      logic [RA_W-1:0] wreg;
      logic [RA_W-1:0] rs;
      logic [RA_W-1:0] rt;
      logic            use_rs;
      logic            use_rt;
   } ent_t;

   localparam logic BR_MEM = (BR_STAGE == 3);
   localparam logic LL2    = (LOAD_LAT == 2);

   ent_t ex_q;
   ent_t mem_q;
   ent_t wb_q;
   ent_t id_e;

   logic ld_ex;
   logic ld_mem;
   logic jmp_fl;
   logic stall_c;
   logic flush_ev;
   logic ex_load;

   function automatic logic hit(
      input ent_t            s,
      input logic [RA_W-1:0] r
   );
      return s.valid && s.regwrite &&
             (s.wreg == r) && (r != '0);
   endfunction

   function automatic logic [1:0] fsel(
      input logic            used,
      input logic [RA_W-1:0] r,
      input ent_t            m,
      input ent_t            w
   );
      if (!used)
         return 2'b00;
      if (hit(m, r))
         return m.memread ? 2'b00 : 2'b10;
      if (hit(w, r))
         return 2'b01;
      return 2'b00;
   endfunction

   // Pack the ID-stage fields into a shadow entry.
   always_comb begin
      id_e          = '0;
      id_e.valid    = id_valid;
      id_e.regwrite = id_regwrite;
      id_e.memread  = id_memread;
      id_e.wreg     = id_wreg;
      id_e.rs       = id_rs;
      id_e.rt       = id_rt;
      id_e.use_rs   = id_use_rs;
      id_e.use_rt   = id_use_rt;
   end

   assign ld_ex = ex_q.memread &
                  ((id_use_rs & hit(ex_q, id_rs)) |
                   (id_use_rt & hit(ex_q, id_rt)));

   assign ld_mem = LL2 & mem_q.memread &
                   ((id_use_rs & hit(mem_q, id_rs)) |
                    (id_use_rt & hit(mem_q, id_rt)));

   // A jump only kills the fetch slot; it is never held.
   assign jmp_fl  = id_valid & id_jump & ~br_taken;
   assign stall_c = id_valid & (ld_ex | ld_mem) &
                    ~br_taken & ~jmp_fl;
   assign flush_ev = br_taken | jmp_fl;
   assign ex_load  = id_valid & ~stall_c & ~br_taken;

   // Every control output is forced low while reset is held.
   always_comb begin
      stall       = stall_c & reset;
      bubble_idex = stall_c & reset;
      flush_ifid  = (br_taken | jmp_fl) & reset;
      flush_idex  = br_taken & reset;
      flush_exmem = BR_MEM & br_taken & reset;
   end

   // EX operand selects; MEM beats WB, a MEM load never forwards.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (reset && ex_q.valid) begin
         fwd_a = fsel(ex_q.use_rs, ex_q.rs, mem_q, wb_q);
         fwd_b = fsel(ex_q.use_rt, ex_q.rt, mem_q, wb_q);
      end
   end

   // Advance the shadow; bubbles and flushes enter as empty slots.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         wb_q  <= mem_q;
         mem_q <= (BR_MEM && br_taken) ? '0 : ex_q;
         ex_q  <= ex_load ? id_e : '0;
      end
   end

   // Saturating count of stall cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_cnt <= '0;
      else if (stall_c && (stall_cnt != '1))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

   // Saturating count of redirect events, one per cycle at most.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         flush_cnt <= '0;
      else if (flush_ev && (flush_cnt != '1))
         flush_cnt <= flush_cnt + CNT_W'(1);
   end

   // Shadow fields that only matter for the EX entry.
   logic unused_fields;
   assign unused_fields = ^{wb_q.memread, wb_q.rs, wb_q.rt,
                            wb_q.use_rs, wb_q.use_rt,
                            mem_q.rs, mem_q.rt,
                            mem_q.use_rs, mem_q.use_rt};

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit.
// Two instances: default and LOAD_LAT=2/BR_STAGE=2/CNT_W=4.
module tb_hazard_forward_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_use_rs;
   logic       id_use_rt;
   logic       id_regwrite;
   logic       id_memread;
   logic [4:0] id_wreg;
   logic       id_jump;
   logic       br_taken;

   logic        stall, bubble, fl_if, fl_ie, fl_em;
   logic [1:0]  fwd_a, fwd_b;
   logic [15:0] scnt, fcnt;

   logic        stall2, bubble2, fl_if2, fl_ie2, fl_em2;
   logic [1:0]  fwd_a2, fwd_b2;
   logic [3:0]  scnt2, fcnt2;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   hazard_forward_unit dut (
      .clk         (clk),
      .reset       (reset),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_use_rs   (id_use_rs),
      .id_use_rt   (id_use_rt),
      .id_regwrite (id_regwrite),
      .id_memread  (id_memread),
      .id_wreg     (id_wreg),
      .id_jump     (id_jump),
      .br_taken    (br_taken),
      .stall       (stall),
      .bubble_idex (bubble),
      .flush_ifid  (fl_if),
      .flush_idex  (fl_ie),
      .flush_exmem (fl_em),
      .fwd_a       (fwd_a),
      .fwd_b       (fwd_b),
      .stall_cnt   (scnt),
      .flush_cnt   (fcnt)
   );

   hazard_forward_unit #(
      .LOAD_LAT (2),
      .BR_STAGE (2),
      .CNT_W    (4)
   ) dut2 (
      .clk         (clk),
      .reset       (reset),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_use_rs   (id_use_rs),
      .id_use_rt   (id_use_rt),
      .id_regwrite (id_regwrite),
      .id_memread  (id_memread),
      .id_wreg     (id_wreg),
      .id_jump     (id_jump),
      .br_taken    (br_taken),
      .stall       (stall2),
      .bubble_idex (bubble2),
      .flush_ifid  (fl_if2),
      .flush_idex  (fl_ie2),
      .flush_exmem (fl_em2),
      .fwd_a       (fwd_a2),
      .fwd_b       (fwd_b2),
      .stall_cnt   (scnt2),
      .flush_cnt   (fcnt2)
   );

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      id_valid    = 1'b0;
      id_rs       = '0;
      id_rt       = '0;
      id_use_rs   = 1'b0;
      id_use_rt   = 1'b0;
      id_regwrite = 1'b0;
      id_memread  = 1'b0;
      id_wreg     = '0;
      id_jump     = 1'b0;
      br_taken    = 1'b0;
   endtask

   task automatic put(
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic       urs,
      input logic       urt,
      input logic       rw,
      input logic       mr,
      input logic [4:0] wr
   );
      id_valid    = 1'b1;
      id_rs       = rs;
      id_rt       = rt;
      id_use_rs   = urs;
      id_use_rt   = urt;
      id_regwrite = rw;
      id_memread  = mr;
      id_wreg     = wr;
      id_jump     = 1'b0;
      br_taken    = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      tick();
      tick();
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   initial begin
      idle();
      reset = 1'b0;
      #2;
      // junk inputs while in reset
      put(4, 4, 1, 1, 1, 1, 4);
      br_taken = 1'b1;
      id_jump  = 1'b1;
      settle();
      chk("rst_stall", stall, 0);
      chk("rst_flush", {fl_if, fl_ie, fl_em}, 0);
      chk("rst_fwd", {fwd_a, fwd_b}, 0);
      chk("rst_cnt", {scnt, fcnt}, 0);

      // EX/MEM forwarding
      do_reset();
      put(1, 2, 1, 1, 1, 0, 3);
      settle();
      chk("fw_add_stall", stall, 0);
      tick();
      put(3, 4, 1, 1, 1, 0, 7);
      settle();
      chk("fw_sub_id_stall", stall, 0);
      chk("fw_add_ex_a", fwd_a, 2'b00);
      tick();
      put(8, 9, 1, 1, 1, 0, 10);
      settle();
      chk("fw_sub_ex_a", fwd_a, 2'b10);
      chk("fw_sub_ex_b", fwd_b, 2'b00);
      chk("fw_sub_ex_stall", stall, 0);
      tick();
      idle();
      settle();
      chk("fw_indep_a", fwd_a, 2'b00);

      // MEM wins over WB
      put(1, 2, 1, 1, 1, 0, 3);
      tick();
      put(5, 6, 1, 1, 1, 0, 3);
      tick();
      put(3, 3, 1, 1, 1, 0, 9);
      tick();
      idle();
      settle();
      chk("prio_a", fwd_a, 2'b10);
      chk("prio_b", fwd_b, 2'b10);

      // load-use, LOAD_LAT=1
      do_reset();
      put(1, 0, 1, 0, 1, 1, 4);
      tick();
      put(4, 6, 1, 1, 1, 0, 5);
      settle();
      chk("lu1_stall", stall, 1);
      chk("lu1_bubble", bubble, 1);
      tick();
      settle();
      chk("lu1_stall2", {stall, bubble}, 0);
      tick();
      idle();
      settle();
      chk("lu1_fwd_a", fwd_a, 2'b01);
      chk("lu1_fwd_b", fwd_b, 2'b00);
      chk("lu1_scnt", scnt, 1);

      // load-use, LOAD_LAT=2
      do_reset();
      put(1, 0, 1, 0, 1, 1, 4);
      tick();
      put(4, 6, 1, 1, 1, 0, 5);
      settle();
      chk("lu2_stall_c1", stall2, 1);
      tick();
      settle();
      chk("lu2_stall_c2", {stall2, bubble2}, 2'b11);
      tick();
      settle();
      chk("lu2_stall_c3", stall2, 0);
      tick();
      idle();
      settle();
      chk("lu2_scnt", scnt2, 2);

      // taken branch beats pending load-use
      do_reset();
      put(1, 2, 1, 1, 1, 0, 3);
      tick();
      put(1, 0, 1, 0, 1, 1, 4);
      tick();
      put(4, 5, 1, 1, 1, 0, 6);
      br_taken = 1'b1;
      settle();
      chk("br_flush", {fl_if, fl_ie, fl_em}, 3'b111);
      chk("br_stall", {stall, bubble}, 0);
      chk("br_exmem_bs2", fl_em2, 0);
      tick();
      put(4, 3, 1, 1, 1, 0, 7);
      settle();
      chk("br_ex_empty", stall, 0);
      chk("br_fcnt", fcnt, 1);
      chk("br_scnt", scnt, 0);
      chk("br_noflush", {fl_if, fl_ie, fl_em}, 0);
      tick();
      idle();
      settle();
      chk("br_mem_empty", fwd_a, 2'b00);

      // register 0 and jumps
      do_reset();
      put(1, 0, 1, 0, 1, 1, 0);
      tick();
      put(0, 0, 1, 1, 1, 0, 0);
      settle();
      chk("r0_ld_stall", stall, 0);
      tick();
      put(0, 0, 1, 1, 1, 0, 5);
      tick();
      idle();
      settle();
      chk("r0_fwd", {fwd_a, fwd_b}, 0);
      id_valid = 1'b1;
      id_jump  = 1'b1;
      settle();
      chk("jmp_flush", {fl_if, fl_ie, fl_em}, 3'b100);
      chk("jmp_stall", stall, 0);
      tick();
      br_taken = 1'b1;
      settle();
      chk("jmp_fcnt", fcnt, 1);
      tick();
      idle();
      settle();
      chk("jmp_br_once", fcnt, 2);

      // stall counter saturation, then async reset
      do_reset();
      put(4, 0, 1, 0, 1, 1, 4);
      repeat (30) tick();
      settle();
      chk("sat_scnt", scnt2, 15);
      tick();
      settle();
      chk("sat_midstall", stall2, 1);
      reset = 1'b0;
      #1;
      chk("ar_ctl2", {stall2, bubble2, fl_if2, fl_ie2, fl_em2}, 0);
      chk("ar_cnt2", {scnt2, fcnt2}, 0);
      chk("ar_ctl", {stall, bubble, fwd_a, fwd_b}, 0);
      chk("ar_cnt", {scnt, fcnt}, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      put(4, 0, 1, 0, 0, 0, 0);
      settle();
      chk("ar_empty", stall2, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised hazard controller for the 5-stage MIPS32 pipeline: IF, ID, EX, MEM, WB.
- Keeps a shadow scoreboard of the instructions in EX, MEM and WB.
- From the scoreboard it generates:
  - load-use stalls,
  - EX-stage operand forwarding selects,
  - branch/jump flushes.
- Counts stall and flush events in saturating counters.
- Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their hold/flush inputs and the EX operand muxes.

Parameters:
- RA_W, 5, register address width.
- LOAD_LAT, 1, number of load-use bubble cycles; legal values 1 or 2.
- BR_STAGE, 3, stage where a branch resolves: 2 = EX, 3 = MEM.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  the IF/ID register holds a real instruction.
- id_rs  in  RA_W  rs field of the ID instruction.
- id_rt  in  RA_W  rt field of the ID instruction.
- id_use_rs  in  1  the ID instruction reads rs.
- id_use_rt  in  1  the ID instruction reads rt.
- id_regwrite  in  1  the ID instruction writes a register.
- id_memread  in  1  the ID instruction is a load.
- id_wreg  in  RA_W  destination register after the RegDst mux.
- id_jump  in  1  the ID instruction is a jump.
- br_taken  in  1  the branch currently in stage BR_STAGE is taken.
- stall  out  1  hold PC and IF/ID.
- bubble_idex  out  1  load zero control bits into ID/EX.
- flush_ifid  out  1  clear IF/ID.
- flush_idex  out  1  clear ID/EX.
- flush_exmem  out  1  clear EX/MEM; driven only when BR_STAGE=3.
- fwd_a  out  2  EX ALU A select: 00 = ID/EX, 01 = MEM/WB, 10 = EX/MEM.
- fwd_b  out  2  same encoding for the EX ALU B operand.
- stall_cnt  out  CNT_W  number of stall cycles.
- flush_cnt  out  CNT_W  number of taken-branch or jump events.

Behaviour:
- Shadow entries: EX, MEM, WB. Each entry holds {valid, regwrite, memread, wreg, rs, rt, use_rs, use_rt}.
- Reset (reset=0, asynchronous): all entries go invalid, counters go to 0. All outputs read 0 for the whole time reset is low.
- Every clock edge the shadow advances:
  - WB ← MEM, MEM ← EX.
  - EX ← ID fields when id_valid=1 and neither bubble_idex nor flush_idex is asserted; otherwise EX goes invalid.
- Match(s, r): s.valid & s.regwrite & s.wreg==r & r!=0. Register 0 never matches.
- Load-use stall:
  - stall=1 when id_valid and an ID source in use matches a load in EX.
  - When LOAD_LAT=2, a match with a load in MEM also stalls.
  - bubble_idex equals stall.
  - Stall, bubble and all flush outputs are combinational from the shadow entries and current inputs.
- Forwarding, computed combinationally for the EX entry's sources:
  - If the EX entry is invalid or the source is not used, select 00.
  - 10 if the source matches MEM and MEM is not a load.
  - Else 01 if the source matches WB.
  - Else 00.
  - When both MEM and WB match, MEM wins.
  - A load in MEM never forwards 10. Such a case is prevented by the stall; if it occurs anyway, select 00.
- Branch taken (br_taken=1):
  - flush_ifid=1 and flush_idex=1.
  - flush_exmem=1 only when BR_STAGE=3.
  - The shadow entries younger than the branch go invalid on the next edge.
  - stall and bubble_idex are forced to 0 that cycle: flush has priority over stall.
- Jump:
  - id_jump & id_valid & ~br_taken gives flush_ifid=1 for one cycle.
  - No stall is applied to the jump itself.
- Counters:
  - stall_cnt +1 on each cycle with stall=1.
  - flush_cnt +1 on each cycle with br_taken, or with a jump flush when br_taken is low. A cycle where both occur counts once.
  - Both counters saturate at all-ones and never wrap.
- Latency:
  - Stall, flush and forward outputs are valid in the same cycle as their inputs.
  - The shadow updates one edge later.
- Reset asserted mid-stall or mid-flush: outputs drop to 0 immediately. After release, the unit restarts with an empty shadow.

Test Plan:
- Forward from EX/MEM: add $3 then sub using $3 → sub in EX gives fwd_a=10, stall=0. Next independent cycle gives 00.
- Load-use, LOAD_LAT=1: lw $4 then add $5,$4,$6 → stall=1 and bubble_idex=1 for 1 cycle. Then add in EX gives fwd_a=01. stall_cnt=1.
- Load-use, LOAD_LAT=2: same sequence → stall for 2 consecutive cycles, then fwd_a=01. stall_cnt=2.
- Taken branch, BR_STAGE=3, with a load-use pending in ID the same cycle → flush_ifid=flush_idex=flush_exmem=1 and stall=0. flush_cnt=1. Shadow EX and MEM are invalid next cycle.
- Register 0: add $0 followed by a reader of $0 → fwd_a=fwd_b=00, stall=0. Jump in ID → flush_ifid only.
- Counter saturation with CNT_W=4: run 20 load-use stalls → stall_cnt holds 15. Then assert reset mid-stall → all outputs 0 asynchronously and counters 0.
